ga23_vram_sched: RTL and testbench
==================================

# ga23_vram_sched

Time-slot scheduler that shares the GA23 single-port tile VRAM among the three tilemap layer fetchers, the CPU and the per-line rowscroll fetch. It runs an 8-slot cycle on the pixel clock enable, resynchronised to each line by `hpulse`, and inserts a 12-slot rowscroll burst once per line. It sits between the CPU bus interface, the VRAM macro and the three `ga23_layer` instances.

## Interface
Parameters:
- RS_BASE0, 15'h7a00, word address of layer 0 rowscroll table
- RS_BASE1, 15'h7c00, word address of layer 1 rowscroll table
- RS_BASE2, 15'h7e00, word address of layer 2 rowscroll table

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- ce  in  1  pixel clock enable; slot logic advances only when high
- hpulse  in  1  line-start strobe, qualified by ce
- vcnt  in  10  current line
- y_ofs0/1/2  in  10 each  layer vertical scroll
- layer_addr0/1/2  in  15 each  layer tile word address (bit 0 = 0)
- layer_load  out  3  one-ce strobe per layer: index in vram_latch, attribute on vram_din
- vram_latch  out  16  latched tile index word
- rowscroll0/1/2  out  10 each  current line's rowscroll values
- cpu_req  in  1  one-clk access request (any clk, ignores ce)
- cpu_we  in  1  write qualifier, sampled with cpu_req
- cpu_addr  in  15  CPU word address, held stable while cpu_busy
- cpu_din  in  16  CPU write data, held stable while cpu_busy
- cpu_dout  out  16  CPU read data
- cpu_busy  out  1  high from clk after cpu_req until access complete
- vram_addr  out  15  VRAM word address
- vram_we  out  1  one-clk write strobe
- vram_dout  out  16  VRAM write data
- vram_din  in  16  VRAM read data; valid one ce after vram_addr registered

## Operation
- Reset: every output 0; slot counter 0; CPU pending, rs_pending, rs_active cleared. Reset mid-access abandons it with no write.
- Slot counter (3 bits) increments each ce, wraps 7->0; hpulse loads 7 and sets rs_pending. Action of the current slot always executes.
- Slots 0/2/4: vram_addr <= layer_addr{0,1,2}.
- Slots 1/3/5: vram_latch <= vram_din; vram_addr[0] <= 1; layer_load bit {0,1,2} high for this ce only.
- Slot 6: if CPU pending, vram_addr <= cpu_addr, vram_dout <= cpu_din, vram_we <= cpu_we (one clk), state -> granted.
- Slot 7: if granted, cpu_dout <= vram_din (also for writes), cpu_busy drops. If rs_pending, clear it, set rs_active, rs_cyc <= 0.
- Rowscroll (rs_active): slot counter frozen, layer/CPU slots suppressed, CPU stays pending. rs_cyc 0..11: at 4k vram_addr <= RS_BASEk + ((y_ofs_k + vcnt) mod 512); at 4k+2 rowscroll_k <= vram_din[9:0]; at 11 rs_active clears, slot counter resumes at 0 next ce.
- hpulse during rs_active: rs_pending not set, counter not reloaded.
- cpu_req while cpu_busy: ignored.

## Timing
- CPU worst-case latency: 8 ce + 12 ce rowscroll; best case cpu_busy high 2 ce.
- cpu_req and slot 6 on same clk: not granted until the next slot 6.
- Row-address sum 10-bit, bits [8:0] used.
- layer_load asserted exactly 3 times per non-rowscroll 8-slot cycle.

## Structure
- ga23_pkg: slot enum (SLOT_L0A..SLOT_CPU_DONE), rowscroll cycle length constant, default RS base constants.
- Sub-module ga23_rowscroll_seq: rs_cyc counter, address generation and capture registers; top holds slot counter and CPU handshake.

## Test plan
- Reset, ce every clk, layer_addr0=15'h0100 -> vram_addr 15'h0100 at slot 0, 15'h0101 at slot 1, layer_load=3'b001 for one ce.
- cpu_req, cpu_we=1, cpu_addr=15'h1234, cpu_din=16'hBEEF -> one-clk vram_we with that addr/data at slot 6, cpu_busy low after slot 7.
- CPU read, VRAM model holds 16'hA5A5 at 15'h0042 -> cpu_dout=16'hA5A5 when cpu_busy falls.
- hpulse, vcnt=10, y_ofs0=10'd505 -> rowscroll read at 15'h7a00+3 (515 mod 512); rowscroll0 takes stored value; slot counter resumes at 0.
- cpu_req one clk after hpulse -> grant deferred past the 12-ce burst, completes within 20 ce.
- Reset asserted while cpu_busy -> no vram_we, cpu_busy and all outputs 0 next clk.

Source files
------------

// File: rtl/ga23_vram_sched_pkg.sv
// ga23_vram_sched_pkg: shared slot/handshake types and rowscroll constants for the GA23 VRAM scheduler.
package ga23_vram_sched_pkg;

    typedef enum logic [2:0] {
        SLOT_L0A,
        SLOT_L0B,
        SLOT_L1A,
        SLOT_L1B,
        SLOT_L2A,
        SLOT_L2B,
        SLOT_CPU,
        SLOT_CPU_DONE
    } slot_t;

    typedef enum logic [1:0] {
        CPU_IDLE,
        CPU_PEND,
        CPU_GRANT
    } cpu_state_t;

    localparam int RS_CYCLES = 12;

    localparam logic [14:0] RS_BASE0_DEF = 15'h7a00;
    localparam logic [14:0] RS_BASE1_DEF = 15'h7c00;
    localparam logic [14:0] RS_BASE2_DEF = 15'h7e00;

    // Tables are 512 entries, so the line sum wraps at 9 bits.
    function automatic logic [14:0] rs_row_addr(input logic [14:0] base, input logic [9:0] y_ofs,
                                                input logic [9:0] vcnt);
        logic [9:0] s;
        s = y_ofs + vcnt;
        return base + 15'(s & 10'h1ff);
    endfunction

endpackage

// File: rtl/ga23_vram_sched_if.sv
// ga23_vram_sched_if: CPU access port of the VRAM scheduler.
interface ga23_vram_sched_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [14:0] cpu_addr;
    logic [15:0] cpu_din;
    logic [15:0] cpu_dout;
    logic        cpu_busy;

    modport master (output cpu_req, cpu_we, cpu_addr, cpu_din, input cpu_dout, cpu_busy);
    modport slave  (input cpu_req, cpu_we, cpu_addr, cpu_din, output cpu_dout, cpu_busy);
endinterface

// File: rtl/ga23_vram_sched_rowscroll.sv
// ga23_vram_sched_rowscroll: 12-cycle per-line rowscroll burst; one address and one capture per layer.
module ga23_vram_sched_rowscroll
    import ga23_vram_sched_pkg::*;
#(
    parameter logic [14:0] RS_BASE0 = RS_BASE0_DEF,
    parameter logic [14:0] RS_BASE1 = RS_BASE1_DEF,
    parameter logic [14:0] RS_BASE2 = RS_BASE2_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        start,
    input  logic [9:0]  vcnt,
    input  logic [9:0]  y_ofs0,
    input  logic [9:0]  y_ofs1,
    input  logic [9:0]  y_ofs2,
    input  logic [9:0]  rs_din,
    output logic        active,
    output logic        last,
    output logic        addr_en,
    output logic [14:0] addr,
    output logic [9:0]  rowscroll0,
    output logic [9:0]  rowscroll1,
    output logic [9:0]  rowscroll2
);

    logic [3:0] cyc;
    logic [1:0] lane;
    logic       cap;

    assign lane    = cyc[3:2];
    assign last    = active && cyc == 4'(RS_CYCLES - 1);
    assign addr_en = active && cyc[1:0] == 2'd0;
    assign cap     = active && cyc[1:0] == 2'd2;
    assign addr    = lane == 2'd0 ? rs_row_addr(RS_BASE0, y_ofs0, vcnt) :
                     lane == 2'd1 ? rs_row_addr(RS_BASE1, y_ofs1, vcnt) :
                                    rs_row_addr(RS_BASE2, y_ofs2, vcnt);

    always_ff @(posedge clk) begin
        if (reset) begin
            active     <= 1'b0;
            cyc        <= 4'd0;
            rowscroll0 <= 10'd0;
            rowscroll1 <= 10'd0;
            rowscroll2 <= 10'd0;
        end else if (ce) begin
            if (active) begin
                active <= !last;
                cyc    <= cyc + 4'd1;
            end else if (start) begin
                active <= 1'b1;
                cyc    <= 4'd0;
            end
            if (cap && lane == 2'd0) rowscroll0 <= rs_din;
            if (cap && lane == 2'd1) rowscroll1 <= rs_din;
            if (cap && lane == 2'd2) rowscroll2 <= rs_din;
        end
    end

endmodule

// File: rtl/ga23_vram_sched.sv
// ga23_vram_sched: 8-slot VRAM time-slot scheduler for three tile layers, the CPU and a per-line rowscroll burst.
module ga23_vram_sched
    import ga23_vram_sched_pkg::*;
#(
    parameter logic [14:0] RS_BASE0 = RS_BASE0_DEF,
    parameter logic [14:0] RS_BASE1 = RS_BASE1_DEF,
    parameter logic [14:0] RS_BASE2 = RS_BASE2_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        hpulse,
    input  logic [9:0]  vcnt,
    input  logic [9:0]  y_ofs0,
    input  logic [9:0]  y_ofs1,
    input  logic [9:0]  y_ofs2,
    input  logic [14:0] layer_addr0,
    input  logic [14:0] layer_addr1,
    input  logic [14:0] layer_addr2,
    output logic [2:0]  layer_load,
    output logic [15:0] vram_latch,
    output logic [9:0]  rowscroll0,
    output logic [9:0]  rowscroll1,
    output logic [9:0]  rowscroll2,
    ga23_vram_sched_if.slave cpu,
    output logic [14:0] vram_addr,
    output logic        vram_we,
    output logic [15:0] vram_dout,
    input  logic [15:0] vram_din
);

    slot_t       slot;
    cpu_state_t  cpu_st, cpu_st_n;
    logic        we_q;
    logic        rs_pending;
    logic        rs_active, rs_last, rs_addr_en, rs_start;
    logic        slot_go;
    logic [14:0] rs_addr, layer_sel;
    logic [15:0] cpu_dout_q;

    assign slot_go       = ce && !rs_active;
    assign rs_start      = slot_go && slot == SLOT_CPU_DONE && rs_pending;
    assign layer_sel     = slot[2:1] == 2'd0 ? layer_addr0 : slot[2:1] == 2'd1 ? layer_addr1 : layer_addr2;
    assign cpu.cpu_busy  = cpu_st != CPU_IDLE;
    assign cpu.cpu_dout  = cpu_dout_q;

    ga23_vram_sched_rowscroll #(
        .RS_BASE0(RS_BASE0),
        .RS_BASE1(RS_BASE1),
        .RS_BASE2(RS_BASE2)
    ) u_rs (
        .clk(clk),
        .reset(reset),
        .ce(ce),
        .start(rs_start),
        .vcnt(vcnt),
        .y_ofs0(y_ofs0),
        .y_ofs1(y_ofs1),
        .y_ofs2(y_ofs2),
        .rs_din(vram_din[9:0]),
        .active(rs_active),
        .last(rs_last),
        .addr_en(rs_addr_en),
        .addr(rs_addr),
        .rowscroll0(rowscroll0),
        .rowscroll1(rowscroll1),
        .rowscroll2(rowscroll2)
    );

    // A request seen on the same clk as slot 6 is only pending from the next clk, so it waits a full cycle.
    always_comb begin
        cpu_st_n = cpu_st;
        case (cpu_st)
            CPU_IDLE:  cpu_st_n = cpu.cpu_req ? CPU_PEND : CPU_IDLE;
            CPU_PEND:  cpu_st_n = (slot_go && slot == SLOT_CPU) ? CPU_GRANT : CPU_PEND;
            CPU_GRANT: cpu_st_n = (slot_go && slot == SLOT_CPU_DONE) ? CPU_IDLE : CPU_GRANT;
            default:   cpu_st_n = CPU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_st <= CPU_IDLE;
            we_q   <= 1'b0;
        end else begin
            cpu_st <= cpu_st_n;
            if (cpu_st == CPU_IDLE && cpu.cpu_req) we_q <= cpu.cpu_we;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot       <= SLOT_L0A;
            rs_pending <= 1'b0;
        end else if (ce) begin
            if (rs_active) begin
                if (rs_last) slot <= SLOT_L0A;
            end else begin
                slot       <= hpulse ? SLOT_CPU_DONE : slot_t'(slot + 3'd1);
                rs_pending <= hpulse || (rs_pending && slot != SLOT_CPU_DONE);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vram_addr  <= 15'd0;
            vram_we    <= 1'b0;
            vram_dout  <= 16'd0;
            vram_latch <= 16'd0;
            layer_load <= 3'd0;
            cpu_dout_q <= 16'd0;
        end else begin
            vram_we <= 1'b0;
            if (ce) begin
                layer_load <= 3'd0;
                if (rs_active) begin
                    if (rs_addr_en) vram_addr <= rs_addr;
                end else begin
                    case (slot)
                        SLOT_L0A, SLOT_L1A, SLOT_L2A: vram_addr <= layer_sel;
                        SLOT_L0B, SLOT_L1B, SLOT_L2B: begin
                            vram_latch   <= vram_din;
                            vram_addr[0] <= 1'b1;
                            layer_load   <= 3'b001 << slot[2:1];
                        end
                        SLOT_CPU: if (cpu_st == CPU_PEND) begin
                            vram_addr <= cpu.cpu_addr;
                            vram_dout <= cpu.cpu_din;
                            vram_we   <= we_q;
                        end
                        default: if (cpu_st == CPU_GRANT) cpu_dout_q <= vram_din;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_ga23_vram_sched.sv
// tb_ga23_vram_sched: directed plus random stimulus against a per-ce schedule model of the VRAM scheduler.
module tb_ga23_vram_sched;

    localparam logic [14:0] RS0 = 15'h7a00;
    localparam logic [14:0] RS1 = 15'h7c00;
    localparam logic [14:0] RS2 = 15'h7e00;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b0;
    logic        hpulse = 1'b0;
    logic [9:0]  vcnt = 10'd0;
    logic [9:0]  yo [3];
    logic [14:0] la [3];
    logic [2:0]  layer_load;
    logic [15:0] vram_latch;
    logic [9:0]  rowscroll0, rowscroll1, rowscroll2;
    logic [14:0] vram_addr;
    logic        vram_we;
    logic [15:0] vram_dout, vram_din;

    int vec = 0;
    int mis = 0;
    bit chk_on = 0;

    ga23_vram_sched_if cpu();

    ga23_vram_sched dut (
        .clk(clk), .reset(reset), .ce(ce), .hpulse(hpulse), .vcnt(vcnt),
        .y_ofs0(yo[0]), .y_ofs1(yo[1]), .y_ofs2(yo[2]),
        .layer_addr0(la[0]), .layer_addr1(la[1]), .layer_addr2(la[2]),
        .layer_load(layer_load), .vram_latch(vram_latch),
        .rowscroll0(rowscroll0), .rowscroll1(rowscroll1), .rowscroll2(rowscroll2),
        .cpu(cpu),
        .vram_addr(vram_addr), .vram_we(vram_we), .vram_dout(vram_dout), .vram_din(vram_din)
    );

    always #5 clk = ~clk;

    // VRAM macro: read data follows the registered address, writes land on the strobe clk.
    logic [15:0] vmem [32768];
    logic [15:0] rmem [32768];
    assign vram_din = vmem[vram_addr];
    always @(posedge clk) if (vram_we) vmem[vram_addr] <= vram_dout;

    // Reference: what each ce does, derived from the slot/rowscroll schedule.
    int          m_slot = 0, m_cyc = 0;
    bit          m_pend = 0, m_grant = 0, m_busy = 0, m_rsp = 0, m_rsa = 0, m_wq = 0;
    logic [14:0] e_addr = 0;
    logic        e_we = 0;
    logic [15:0] e_dout = 0, e_latch = 0, e_cdout = 0;
    logic [2:0]  e_ll = 0;
    logic [9:0]  e_rs [3];
    logic [14:0] rsb [3];

    initial begin
        rsb[0] = RS0; rsb[1] = RS1; rsb[2] = RS2;
        e_rs[0] = 0; e_rs[1] = 0; e_rs[2] = 0;
    end

    always @(posedge clk) begin : model
        logic [14:0] a0;
        logic        w0, req_ok;
        logic [15:0] d0;
        int          s, k;
        a0 = e_addr; w0 = e_we; d0 = e_dout;
        req_ok = cpu.cpu_req && !m_busy;
        if (reset) begin
            m_slot = 0; m_cyc = 0; m_pend = 0; m_grant = 0; m_busy = 0; m_rsp = 0; m_rsa = 0; m_wq = 0;
            e_addr = 0; e_we = 0; e_dout = 0; e_latch = 0; e_cdout = 0; e_ll = 0;
            e_rs[0] = 0; e_rs[1] = 0; e_rs[2] = 0;
        end else begin
            e_we = 0;
            if (ce) begin
                e_ll = 0;
                if (m_rsa) begin
                    k = m_cyc / 4;
                    if (m_cyc % 4 == 0) e_addr = rsb[k] + 15'((int'(yo[k]) + int'(vcnt)) % 512);
                    if (m_cyc % 4 == 2) e_rs[k] = rmem[a0][9:0];
                    if (m_cyc == 11) begin m_rsa = 0; m_slot = 0; end
                    else m_cyc++;
                end else begin
                    s = m_slot;
                    m_slot = hpulse ? 7 : (s + 1) % 8;
                    if (s < 6 && s % 2 == 0) e_addr = la[s/2];
                    if (s < 6 && s % 2 == 1) begin
                        e_latch = rmem[a0];
                        e_addr = a0 | 15'd1;
                        e_ll = 3'(1 << (s / 2));
                    end
                    if (s == 6 && m_pend) begin
                        e_addr = cpu.cpu_addr; e_dout = cpu.cpu_din; e_we = m_wq;
                        m_pend = 0; m_grant = 1;
                    end
                    if (s == 7 && m_grant) begin e_cdout = rmem[a0]; m_busy = 0; m_grant = 0; end
                    if (s == 7 && m_rsp) begin m_rsp = 0; m_rsa = 1; m_cyc = 0; end
                    if (hpulse) m_rsp = 1;
                end
            end
            if (req_ok) begin m_busy = 1; m_pend = 1; m_wq = cpu.cpu_we; end
        end
        if (w0) rmem[a0] = d0;
    end

    always @(negedge clk) begin
        if (chk_on) begin
            logic [97:0] act, exp;
            act = {vram_addr, vram_we, vram_dout, vram_latch, layer_load, cpu.cpu_dout, cpu.cpu_busy,
                   rowscroll0, rowscroll1, rowscroll2};
            exp = {e_addr, e_we, e_dout, e_latch, e_ll, e_cdout, m_busy, e_rs[0], e_rs[1], e_rs[2]};
            vec++;
            if (act !== exp) begin
                mis++;
                $display("FAIL outputs t=%0t addr/we/dout/latch/load/cdout/busy/rs: got %h, expected %h",
                         $time, act, exp);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        vec++;
        if (a !== e) begin
            mis++;
            $display("FAIL %s: got %h, expected %h", name, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setmem(input logic [14:0] a, input logic [15:0] d);
        vmem[a] = d;
        rmem[a] = d;
    endtask

    initial begin
        int n;
        bit seen;
        logic [14:0] a14;
        logic [15:0] old;
        for (int i = 0; i < 32768; i++) setmem(15'(i), 16'(i * 40503 + 7));
        setmem(15'h0042, 16'hA5A5);
        setmem(RS0 + 15'd3, 16'h0123);
        setmem(RS1 + 15'd10, 16'h02AA);
        setmem(RS2 + 15'd98, 16'h0155);
        la[0] = 15'h0100; la[1] = 15'h0200; la[2] = 15'h0300;
        yo[0] = 0; yo[1] = 0; yo[2] = 0;
        cpu.cpu_req = 0; cpu.cpu_we = 0; cpu.cpu_addr = 0; cpu.cpu_din = 0;
        reset = 1; ce = 1;
        tick();
        chk_on = 1;
        tick();
        chk("reset vram_addr", 32'(vram_addr), 0);
        chk("reset busy", 32'(cpu.cpu_busy), 0);
        reset = 0;
        tick();
        chk("slot0 addr", 32'(vram_addr), 32'h0100);
        chk("model slot0 addr", 32'(e_addr), 32'h0100);
        tick();
        chk("slot1 addr", 32'(vram_addr), 32'h0101);
        chk("slot1 load", 32'(layer_load), 32'h1);
        tick();
        chk("slot2 load", 32'(layer_load), 0);
        chk("slot2 addr", 32'(vram_addr), 32'h0200);
        cpu.cpu_req = 1; cpu.cpu_we = 1; cpu.cpu_addr = 15'h1234; cpu.cpu_din = 16'hBEEF;
        tick();
        cpu.cpu_req = 0;
        chk("write busy", 32'(cpu.cpu_busy), 1);
        n = 0;
        while (!vram_we && n < 20) begin tick(); n++; end
        chk("write strobe timeout", 32'(n < 20), 1);
        chk("write addr", 32'(vram_addr), 32'h1234);
        chk("write data", 32'(vram_dout), 32'hBEEF);
        tick();
        chk("write strobe one clk", 32'(vram_we), 0);
        chk("write busy drop", 32'(cpu.cpu_busy), 0);
        chk("write landed", 32'(vmem[15'h1234]), 32'hBEEF);
        cpu.cpu_req = 1; cpu.cpu_we = 0; cpu.cpu_addr = 15'h0042;
        tick();
        cpu.cpu_req = 0;
        n = 0;
        while (cpu.cpu_busy && n < 30) begin tick(); n++; end
        chk("read timeout", 32'(n < 30), 1);
        chk("read data", 32'(cpu.cpu_dout), 32'hA5A5);
        vcnt = 10; yo[0] = 505; yo[1] = 0; yo[2] = 600;
        hpulse = 1;
        tick();
        hpulse = 0;
        cpu.cpu_req = 1; cpu.cpu_we = 0; cpu.cpu_addr = 15'h0042;
        tick();
        cpu.cpu_req = 0;
        n = 0; seen = 0; a14 = 0;
        while (cpu.cpu_busy && n < 40) begin
            tick(); n++;
            if (vram_addr == RS0 + 15'd3) seen = 1;
            if (n == 13) a14 = vram_addr;
        end
        chk("rs addr 7a03 seen", 32'(seen), 1);
        chk("rs cpu latency <=20", 32'(n <= 20), 1);
        chk("rs resume slot0", 32'(a14), 32'h0100);
        chk("rowscroll0", 32'(rowscroll0), 32'h123);
        chk("rowscroll1", 32'(rowscroll1), 32'h2AA);
        chk("rowscroll2", 32'(rowscroll2), 32'h155);
        chk("model rowscroll0", 32'(e_rs[0]), 32'h123);
        old = vmem[15'h0055];
        cpu.cpu_req = 1; cpu.cpu_we = 1; cpu.cpu_addr = 15'h0055; cpu.cpu_din = 16'h1111;
        tick();
        cpu.cpu_req = 0;
        reset = 1;
        tick();
        chk("reset busy mid-access", 32'(cpu.cpu_busy), 0);
        chk("reset no write strobe", 32'(vram_we), 0);
        chk("reset addr", 32'(vram_addr), 0);
        chk("reset layer_load", 32'(layer_load), 0);
        reset = 0;
        repeat (10) tick();
        chk("abandoned write", 32'(vmem[15'h0055]), 32'(old));
        for (int i = 0; i < 4000; i++) begin
            ce = $urandom_range(0, 3) != 0;
            hpulse = $urandom_range(0, 49) == 0;
            reset = $urandom_range(0, 799) == 0;
            cpu.cpu_req = $urandom_range(0, 5) == 0;
            if (!cpu.cpu_busy && cpu.cpu_req) begin
                cpu.cpu_we = 1'($urandom);
                cpu.cpu_addr = 15'($urandom);
                cpu.cpu_din = 16'($urandom);
            end
            if ($urandom_range(0, 15) == 0) begin
                la[$urandom_range(0, 2)] = 15'($urandom) & ~15'd1;
                yo[$urandom_range(0, 2)] = 10'($urandom);
                vcnt = 10'($urandom);
            end
            tick();
        end
        chk_on = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end

endmodule
